// File: rtl/key_bounce_gen.sv
// Key press waveform generator: one start produces press bounce, stable hold,
// release bounce and a stable settle. Bounce segment k lasts STEP_CYCLES*(k+1)
// cycles, so the waveform is deterministic and repeatable.
module key_bounce_gen #(
  parameter int unsigned STEP_CYCLES      = 1,
  parameter int unsigned PRESS_GLITCHES   = 4,
  parameter int unsigned RELEASE_GLITCHES = 2,
  parameter int unsigned HOLD_CYCLES      = 1000,
  parameter int unsigned SETTLE_CYCLES    = 1000,
  parameter logic        PRESSED_LEVEL    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       key_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] edges_o
);

  localparam logic ReleasedLevel = ~PRESSED_LEVEL;

  // Counter sizing: the segment index reaches 2*glitches, the cycle counter
  // reaches one less than the longest segment, hold or settle length.
  localparam int unsigned MaxGlitches = (PRESS_GLITCHES > RELEASE_GLITCHES) ?
                                        PRESS_GLITCHES : RELEASE_GLITCHES;
  localparam int unsigned MaxSeg      = 2 * MaxGlitches;
  localparam int unsigned MaxBounce   = STEP_CYCLES * (MaxSeg + 1);
  localparam int unsigned MaxHs       = (HOLD_CYCLES > SETTLE_CYCLES) ?
                                        HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxCyc      = (MaxBounce > MaxHs) ? MaxBounce : MaxHs;
  localparam int unsigned SegW        = (MaxSeg > 0) ? $clog2(MaxSeg + 1) : 1;
  localparam int unsigned CycW        = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [SegW-1:0] PressLastSeg   = SegW'(2 * PRESS_GLITCHES);
  localparam logic [SegW-1:0] ReleaseLastSeg = SegW'(2 * RELEASE_GLITCHES);
  localparam logic [CycW-1:0] HoldLast       = CycW'(HOLD_CYCLES - 1);
  localparam logic [CycW-1:0] SettleLast     = CycW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StHold,
    StRelease,
    StSettle,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [SegW-1:0]   seg_q, seg_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic              key_q, key_d;
  logic [7:0]        edges_q, edges_d;
  logic [CycW-1:0]   seg_last_cyc;
  logic              seg_end;

  // Last cycle index of the current bounce segment.
  assign seg_last_cyc = CycW'(STEP_CYCLES * (32'(seg_q) + 32'd1) - 32'd1);
  assign seg_end      = (cyc_q == seg_last_cyc);

  // State, counters and the registered key level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      seg_q   <= '0;
      cyc_q   <= '0;
      key_q   <= ReleasedLevel;
      edges_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cyc_q   <= cyc_d;
      key_q   <= key_d;
      edges_q <= edges_d;
    end
  end

  // Sequencing through the segments, key level and edge counting.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cyc_d   = cyc_q;
    key_d   = key_q;
    edges_d = edges_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StPress;
          seg_d   = '0;
          cyc_d   = '0;
        end
      end
      StPress: begin
        if (seg_end) begin
          cyc_d = '0;
          if (seg_q == PressLastSeg) begin
            state_d = StHold;
            seg_d   = '0;
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StHold: begin
        if (cyc_q == HoldLast) begin
          state_d = StRelease;
          seg_d   = '0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StRelease: begin
        if (seg_end) begin
          cyc_d = '0;
          if (seg_q == ReleaseLastSeg) begin
            state_d = StSettle;
            seg_d   = '0;
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StSettle: begin
        if (cyc_q == SettleLast) begin
          state_d = StDone;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Level is a function of where we land, so key_q is glitch-free.
    case (state_d)
      StPress:   key_d = seg_d[0] ? ReleasedLevel : PRESSED_LEVEL;
      StHold:    key_d = PRESSED_LEVEL;
      StRelease: key_d = seg_d[0] ? PRESSED_LEVEL : ReleasedLevel;
      default:   key_d = ReleasedLevel;
    endcase

    // The accepted start itself is the first edge of the sequence.
    if (state_q == StIdle && start_i) begin
      edges_d = 8'd1;
    end else if (key_d != key_q && edges_q != 8'hff) begin
      edges_d = edges_q + 8'd1;
    end
  end

  assign key_o   = key_q;
  assign busy_o  = (state_q == StPress) || (state_q == StHold) ||
                   (state_q == StRelease) || (state_q == StSettle);
  assign done_o  = (state_q == StDone);
  assign edges_o = edges_q;

endmodule
